// File: rtl/bounce_gen.sv
// bounce_gen: emulates a bouncing mechanical switch for debouncer testing.
// LFSR-timed glitch train, then a fixed settle window, then a done pulse.
module bounce_gen #(
    parameter logic [15:0] SEED   = 16'hACE1,
    parameter int unsigned SETTLE = 50
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       target,
    input  logic [3:0] n_bounce,
    input  logic [7:0] max_gap,
    output logic       button,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BOUNCE,
        S_SETTLE
    } state_t;

    // An all-zero seed would lock the LFSR, so fall back to 1.
    localparam logic [15:0] SEED_INIT  = (SEED == 16'd0) ? 16'h0001 : SEED;
    localparam logic [15:0] SETTLE_CNT = 16'(SETTLE);
    localparam logic [15:0] TAPS       = 16'hB400;

    state_t      state, state_n;
    logic [15:0] lfsr;
    logic [15:0] cnt, cnt_n;
    logic [4:0]  rem, rem_n;
    logic [7:0]  mask, mask_n;
    logic        button_n;
    logic        done_n;

    // Hold length 1..256 from the low LFSR byte and the gap mask.
    function automatic logic [15:0] hold(input logic [7:0] r,
                                         input logic [7:0] m);
        logic [8:0] g;
        g = 9'd1 + {1'b0, r & m};
        return {7'd0, g};
    endfunction

    assign busy = (state != S_IDLE);

    // Free-running Galois LFSR, advancing every cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr <= SEED_INIT;
        end else begin
            lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? TAPS : 16'h0000);
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            button <= 1'b0;
            done   <= 1'b0;
            cnt    <= 16'd0;
            rem    <= 5'd0;
            mask   <= 8'd0;
        end else begin
            state  <= state_n;
            button <= button_n;
            done   <= done_n;
            cnt    <= cnt_n;
            rem    <= rem_n;
            mask   <= mask_n;
        end
    end

    // Next-state logic: edge train, settle window, completion pulse.
    always_comb begin
        state_n  = state;
        button_n = button;
        done_n   = 1'b0;
        cnt_n    = cnt;
        rem_n    = rem;
        mask_n   = mask;
        unique case (state)
            S_IDLE: begin
                // A start landing on the done cycle is dropped.
                if (start && !done) begin
                    mask_n = max_gap;
                    rem_n  = {n_bounce, 1'b0};
                    if (target != button) begin
                        button_n = target;
                        cnt_n    = hold(lfsr[7:0], max_gap);
                        state_n  = S_BOUNCE;
                    end else begin
                        cnt_n   = SETTLE_CNT;
                        state_n = S_SETTLE;
                    end
                end
            end
            S_BOUNCE: begin
                if (cnt == 16'd1) begin
                    if (rem == 5'd0) begin
                        cnt_n   = SETTLE_CNT;
                        state_n = S_SETTLE;
                    end else begin
                        button_n = ~button;
                        rem_n    = rem - 5'd1;
                        cnt_n    = hold(lfsr[7:0], mask);
                    end
                end else begin
                    cnt_n = cnt - 16'd1;
                end
            end
            S_SETTLE: begin
                if (cnt == 16'd1) begin
                    cnt_n   = 16'd0;
                    done_n  = 1'b1;
                    state_n = S_IDLE;
                end else begin
                    cnt_n = cnt - 16'd1;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_bounce_gen.sv
// tb_bounce_gen: directed and random checks of bounce_gen against a
// per-cycle expected-output trace built from the event rules.
module tb_bounce_gen;

    localparam logic [15:0] SEED   = 16'hACE1;
    localparam int          SETTLE = 50;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       target = 1'b0;
    logic [3:0] n_bounce = 4'd0;
    logic [7:0] max_gap = 8'd0;
    logic       button;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    bounce_gen #(.SEED(SEED), .SETTLE(SETTLE)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .target(target),
        .n_bounce(n_bounce),
        .max_gap(max_gap),
        .button(button),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic b;
        logic bz;
        logic d;
    } exp_t;

    exp_t        q[$];
    exp_t        cur;
    logic [15:0] m_lfsr;
    bit          m_valid = 0;

    function automatic logic [15:0] step(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic exp_t mk(input logic b, input logic bz,
                                input logic d);
        exp_t e;
        e.b  = b;
        e.bz = bz;
        e.d  = d;
        return e;
    endfunction

    // Expand one accepted event into its cycle-by-cycle output trace.
    task automatic plan(input logic tgt, input logic [3:0] n,
                        input logic [7:0] mg);
        logic [15:0] l;
        logic        lvl;
        int          g;
        l   = m_lfsr;
        lvl = tgt;
        if (tgt != cur.b) begin
            for (int k = 0; k <= 2 * int'(n); k++) begin
                g = 1 + int'(l[7:0] & mg);
                for (int i = 0; i < g; i++) begin
                    q.push_back(mk(lvl, 1'b1, 1'b0));
                    l = step(l);
                end
                lvl = ~lvl;
            end
        end
        for (int i = 0; i < SETTLE; i++) q.push_back(mk(tgt, 1'b1, 1'b0));
        q.push_back(mk(tgt, 1'b0, 1'b1));
    endtask

    // Reference model: consumes the trace one cycle per clock edge.
    always @(posedge clk) begin
        if (reset) begin
            q.delete();
            cur     = mk(1'b0, 1'b0, 1'b0);
            m_lfsr  = (SEED == 16'd0) ? 16'h0001 : SEED;
            m_valid = 1;
        end else if (m_valid) begin
            if (q.size() == 0 && !cur.d && start)
                plan(target, n_bounce, max_gap);
            if (q.size() > 0) cur = q.pop_front();
            else cur = mk(cur.b, 1'b0, 1'b0);
            m_lfsr = step(m_lfsr);
        end
    end

    int   cyc = 0;
    int   edges = 0;
    int   edge_times[$];
    int   done_seen = 0;
    logic prev_b = 1'b0;

    // Compare DUT against the model every cycle; track edges for directed checks.
    always @(negedge clk) begin
        cyc++;
        if (m_valid) begin
            checks++;
            if ({button, busy, done} !== {cur.b, cur.bz, cur.d}) begin
                errors++;
                $display("FAIL trace cyc=%0d got b/busy/done=%b%b%b want %b%b%b",
                         cyc, button, busy, done, cur.b, cur.bz, cur.d);
            end
            if (button !== prev_b) begin
                edges++;
                edge_times.push_back(cyc);
            end
            if (done === 1'b1) done_seen++;
            prev_b = button;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic clr();
        edges = 0;
        edge_times.delete();
        done_seen = 0;
    endtask

    // Pulse start for one edge; returns the index of the first cycle after it.
    task automatic go(input logic t, input logic [3:0] n,
                      input logic [7:0] mg, output int t1);
        start    = 1'b1;
        target   = t;
        n_bounce = n;
        max_gap  = mg;
        tick();
        start = 1'b0;
        t1    = cyc;
    endtask

    // k counts cycles from the start edge (cycle right after it is k=1).
    task automatic wait_done(input int t1, output int k);
        int n;
        n = 0;
        k = cyc - t1 + 1;
        while (done !== 1'b1 && n < 20000) begin
            tick();
            n++;
            k = cyc - t1 + 1;
        end
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL done_timeout got none want done");
            k = -1;
        end
    endtask

    int t1;
    int k;
    int d;
    int ok;

    initial begin
        chk("lfsr_step_pin", int'(step(16'hACE1)), 16'hE270);

        // Two-cycle reset, then a long quiet idle.
        reset = 1'b1;
        tick();
        tick();
        chk("rst_button", int'(button), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        reset = 1'b0;
        clr();
        repeat (100) tick();
        chk("idle_edges", edges, 0);

        // Single clean edge.
        clr();
        go(1'b1, 4'd0, 8'h00, t1);
        chk("clean_rise", int'(button), 1);
        chk("clean_busy", int'(busy), 1);
        wait_done(t1, k);
        chk("clean_done_k", k, SETTLE + 2);
        chk("clean_busy_fall", int'(busy), 0);
        chk("clean_edges", edges, 1);
        tick();

        // Falling to 0 first so the n=3 event rises.
        clr();
        go(1'b0, 4'd0, 8'h00, t1);
        wait_done(t1, k);
        tick();
        clr();
        go(1'b1, 4'd3, 8'h0F, t1);
        wait_done(t1, k);
        chk("b3_edges", edges, 7);
        chk("b3_final", int'(button), 1);
        ok = 1;
        for (int i = 1; i < edge_times.size(); i++) begin
            d = edge_times[i] - edge_times[i-1];
            if (d < 1 || d > 16) ok = 0;
        end
        chk("b3_hold_range", ok, 1);
        if (edge_times.size() > 0)
            chk("b3_settle_gap", (cyc - edge_times[edge_times.size()-1]) >= SETTLE + 1 ? 1 : 0, 1);

        // Start while busy is ignored; start on the done cycle is ignored.
        tick();
        clr();
        go(1'b0, 4'd2, 8'h03, t1);
        tick();
        tick();
        start    = 1'b1;
        target   = 1'b1;
        n_bounce = 4'd5;
        max_gap  = 8'hFF;
        tick();
        start = 1'b0;
        wait_done(t1, k);
        chk("ign_edges", edges, 5);
        chk("ign_final", int'(button), 0);
        start  = 1'b1;
        target = 1'b1;
        tick();
        start = 1'b0;
        chk("done_cycle_start_busy", int'(busy), 0);
        repeat (3) tick();
        chk("done_cycle_start_edges", edges, 5);
        clr();
        go(1'b0, 4'd7, 8'hFF, t1);
        wait_done(t1, k);
        chk("same_level_k", k, SETTLE + 1);
        chk("same_level_edges", edges, 0);
        tick();

        // Reset in the middle of a long bounce train.
        clr();
        go(1'b1, 4'd15, 8'h07, t1);
        k = 0;
        while (edges < 5 && k < 5000) begin
            tick();
            k++;
        end
        chk("abort_reached_5", edges >= 5 ? 1 : 0, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_button", int'(button), 0);
        chk("abort_busy", int'(busy), 0);
        done_seen = 0;
        repeat (300) tick();
        chk("abort_no_done", done_seen, 0);
        clr();
        go(1'b1, 4'd0, 8'h00, t1);
        wait_done(t1, k);
        chk("post_abort_k", k, SETTLE + 2);
        chk("post_abort_edges", edges, 1);
        tick();

        // Zero gap: toggles every cycle.
        clr();
        go(1'b0, 4'd0, 8'h00, t1);
        wait_done(t1, k);
        tick();
        clr();
        go(1'b1, 4'd4, 8'h00, t1);
        wait_done(t1, k);
        chk("zg_edges", edges, 9);
        ok = 1;
        for (int i = 1; i < edge_times.size(); i++)
            if (edge_times[i] - edge_times[i-1] != 1) ok = 0;
        chk("zg_every_cycle", ok, 1);
        chk("zg_final", int'(button), 1);
        chk("zg_done_k", k, 9 + SETTLE + 1);

        // Random traffic, including starts while busy and on done cycles.
        for (int i = 0; i < 3000; i++) begin
            start    = ($urandom % 8) == 0;
            target   = 1'($urandom);
            n_bounce = 4'($urandom % 8);
            max_gap  = 8'($urandom) & 8'h1F;
            tick();
        end
        start = 1'b0;
        k = 0;
        while (busy === 1'b1 && k < 20000) begin
            tick();
            k++;
        end
        chk("rand_drain", int'(busy), 0);
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
